mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single-port program/data memory between the host loader port and the CPU core port.
//   Round-robin arbitration gates CPU access with cpu_en.
//   A built-in clear sequencer sweeps CLR_VALUE into every address on clr_mem.
//   Sits between cpu_top's external load interface and the memory array.
// PARAMETERS
//   ADDR_W     12            address width; the memory holds 2**ADDR_W words
//   DATA_W     32            data word width
//   CLR_VALUE  32'h00000000  value written to every word by the clear sweep
// PORTS
//   main_clk    in   1       system clock; all state changes on the rising edge
//   reset       in   1       asynchronous, active-high reset
//   cpu_en      in   1       1 = CPU port may be granted; 0 = cpu_req masked
//   clr_mem     in   1       clear request, level-sampled in ARB
//   host_req    in   1       host access request
//   host_rw     in   1       1 = write, 0 = read
//   host_addr   in   ADDR_W  host address
//   host_wdata  in   DATA_W  host write data
//   host_gnt    out  1       host request accepted at the next edge (combinational)
//   host_rvalid out  1       host read data valid this cycle
//   host_rdata  out  DATA_W  host read data
//   cpu_req/cpu_rw/cpu_addr/cpu_wdata  in   same as the host_* inputs, for the CPU port
//   cpu_gnt/cpu_rvalid/cpu_rdata       out  same as the host_* outputs, for the CPU port
//   mem_en      out  1       registered memory enable
//   mem_rw      out  1       registered: 1 = write
//   mem_addr    out  ADDR_W  registered memory address
//   mem_wdata   out  DATA_W  registered memory write data
//   mem_rdata   in   DATA_W  memory read data; valid the cycle after mem_en=1 with mem_rw=0
//   busy        out  1       clear sweep in progress
// BEHAVIOUR
//   Reset
//   - All registered outputs go to 0.
//   - State=ARB, clear counter=0, rr_last=CPU, so the host wins the first contention.
//   Handshake (valid/ready)
//   - A requester holds req, rw, addr and wdata stable until it sees gnt=1.
//   - The access is accepted at the edge that ends the gnt cycle.
//   - At most one gnt is high per cycle. gnt is never high in CLEAR or while reset=1.
//   Issue
//   - On the accepting edge, mem_en=1 and mem_rw/mem_addr/mem_wdata load from the winner.
//   - With no grant, mem_en=0 at the next edge.
//   Read latency
//   - A read granted in cycle t drives mem_en in t+1. Memory data returns in t+2.
//   - In t+2, <winner>_rvalid=1 for exactly 1 cycle; <winner>_rdata=mem_rdata (pass-through).
//   - The non-owner rdata is held at 0.
//   - A 1-entry owner pipeline tracks the winner. Back-to-back reads from alternating owners return in issue order.
//   Arbitration (state ARB)
//   - Eligible requesters: host_req, and cpu_req&cpu_en.
//   - One eligible requester: it is granted.
//   - Both eligible: grant the one not granted last. rr_last updates on every grant.
//   - cpu_en falling with a CPU read in flight: cpu_rvalid is still delivered.
//   Clear (state CLEAR)
//   - ARB with clr_mem=1 at an edge -> CLEAR next cycle. clr_mem beats same-cycle requests; no gnt that cycle.
//   - Each CLEAR cycle issues mem_en=1, mem_rw=1, mem_addr=cnt, mem_wdata=CLR_VALUE; cnt increments.
//   - busy=1 throughout CLEAR. The sweep lasts 2**ADDR_W cycles.
//   - After the write to the last address (all ones): cnt wraps to 0, state returns to ARB.
//   - clr_mem is ignored during CLEAR. A level still high on return starts a new sweep.
//   - Reads in flight on CLEAR entry still complete with their rvalid.
//   Reset mid-operation
//   - An in-flight read or a partial sweep is aborted: no rvalid, cnt=0, busy=0, state=ARB.
//   Write then read of the same address on consecutive grants
//   - The read returns the new data; the single port serialises them.
// TESTING
//   - Reset: assert reset with all reqs high -> every output 0, no gnt until reset is released.
//   - Host write then read: write addr 0x007 data 0x0000000a, then read 0x007.
//     -> host_gnt 1 cycle each; host_rvalid 2 cycles after the read gnt with rdata=0x0000000a.
//   - Contention: host_req=cpu_req=1 continuously, cpu_en=1 -> gnt order host,cpu,host,cpu,...
//     with mem_addr alternating accordingly.
//   - CPU masked: cpu_en=0, cpu_req=1 on addr 0x008 -> cpu_gnt stays 0, host is still served.
//     After cpu_en=1 -> cpu_gnt the next cycle.
//   - Clear: preload 0x008=0x000000ff, pulse clr_mem.
//     -> busy for 4096 cycles, mem_addr sweeps 0x000..0xFFF; then a read of 0x008 returns 0x00000000.
//   - Reset mid-clear: assert reset when cnt=0x100 -> busy=0, mem_en=0 immediately.
//     After release: ARB, and a host read is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the host loader and the CPU core.
// Round-robin between ports, CPU gated by cpu_en, plus a full-array clear sweep.
module mem_port_arbiter #(
  parameter int                 ADDR_W    = 12,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  CLR_VALUE = 32'h00000000
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              clr_mem,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_CPU  = 1'b1;

  state_t              state_r;
  logic [ADDR_W-1:0]   cnt_r;
  logic                rr_last_r;
  logic                mem_en_r;
  logic                mem_rw_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                issue_owner_r;
  logic                ret_valid_r;
  logic                ret_owner_r;
  logic                cpu_elig_s;
  logic                host_gnt_s;
  logic                cpu_gnt_s;

  assign cpu_elig_s = cpu_req & cpu_en;

  // Grant decision: only in ARB, never during reset, and a clear request beats both ports.
  always_comb begin
    host_gnt_s = 1'b0;
    cpu_gnt_s  = 1'b0;
    if (!reset && (state_r == ST_ARB) && !clr_mem) begin
      if (host_req && cpu_elig_s) begin
        if (rr_last_r == OWN_CPU) begin
          host_gnt_s = 1'b1;
        end else begin
          cpu_gnt_s = 1'b1;
        end
      end else begin
        host_gnt_s = host_req;
        cpu_gnt_s  = cpu_elig_s;
      end
    end else begin
      host_gnt_s = 1'b0;
      cpu_gnt_s  = 1'b0;
    end
  end

  // State, memory issue registers, clear counter and read-return owner pipeline.
  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_ARB;
      cnt_r         <= {ADDR_W{1'b0}};
      rr_last_r     <= OWN_CPU;
      mem_en_r      <= 1'b0;
      mem_rw_r      <= 1'b0;
      mem_addr_r    <= {ADDR_W{1'b0}};
      mem_wdata_r   <= {DATA_W{1'b0}};
      issue_owner_r <= OWN_HOST;
      ret_valid_r   <= 1'b0;
      ret_owner_r   <= OWN_HOST;
    end else begin
      // Read data comes back one cycle after the issue, independent of the FSM state.
      ret_valid_r <= mem_en_r & ~mem_rw_r;
      ret_owner_r <= issue_owner_r;
      case (state_r)
        ST_ARB: begin
          if (clr_mem) begin
            state_r  <= ST_CLEAR;
            mem_en_r <= 1'b0;
          end else if (host_gnt_s) begin
            mem_en_r      <= 1'b1;
            mem_rw_r      <= host_rw;
            mem_addr_r    <= host_addr;
            mem_wdata_r   <= host_wdata;
            issue_owner_r <= OWN_HOST;
            rr_last_r     <= OWN_HOST;
          end else if (cpu_gnt_s) begin
            mem_en_r      <= 1'b1;
            mem_rw_r      <= cpu_rw;
            mem_addr_r    <= cpu_addr;
            mem_wdata_r   <= cpu_wdata;
            issue_owner_r <= OWN_CPU;
            rr_last_r     <= OWN_CPU;
          end else begin
            mem_en_r <= 1'b0;
          end
        end
        ST_CLEAR: begin
          mem_en_r    <= 1'b1;
          mem_rw_r    <= 1'b1;
          mem_addr_r  <= cnt_r;
          mem_wdata_r <= CLR_VALUE;
          cnt_r       <= cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          if (cnt_r == {ADDR_W{1'b1}}) begin
            state_r <= ST_ARB;
          end else begin
            state_r <= ST_CLEAR;
          end
        end
        default: begin
          state_r  <= ST_ARB;
          mem_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign host_gnt    = host_gnt_s;
  assign cpu_gnt     = cpu_gnt_s;
  assign mem_en      = mem_en_r;
  assign mem_rw      = mem_rw_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wdata   = mem_wdata_r;
  assign busy        = (state_r == ST_CLEAR);
  assign host_rvalid = ret_valid_r & (ret_owner_r == OWN_HOST);
  assign cpu_rvalid  = ret_valid_r & (ret_owner_r == OWN_CPU);
  assign host_rdata  = host_rvalid ? mem_rdata : {DATA_W{1'b0}};
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed stimulus, a behavioural single-port memory,
// and a scoreboard queue of expected read returns checked by an independent monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en, clr_mem;
  logic        host_req, host_rw, cpu_req, cpu_rw;
  logic [11:0] host_addr, cpu_addr;
  logic [31:0] host_wdata, cpu_wdata;
  logic        host_gnt, host_rvalid, cpu_gnt, cpu_rvalid;
  logic [31:0] host_rdata, cpu_rdata;
  logic        mem_en, mem_rw, busy;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .main_clk(clk), .reset(reset), .cpu_en(cpu_en), .clr_mem(clr_mem),
    .host_req(host_req), .host_rw(host_rw), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: registered read, data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_en && mem_rw) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_rw) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per rvalid and checks owner, data, latency and idle rdata.
  always @(negedge clk) begin
    exp_t e;
    if (host_gnt && cpu_gnt) begin
      checks++; errors++;
      $display("FAIL gnt_exclusive: both grants high at cycle %0d", cyc);
    end
    if (host_rvalid && cpu_rvalid) begin
      checks++; errors++;
      $display("FAIL rvalid_exclusive: both rvalids high at cycle %0d", cyc);
    end else if (host_rvalid || cpu_rvalid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rvalid: host=%0b cpu=%0b at cycle %0d", host_rvalid, cpu_rvalid, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_owner", 32'(cpu_rvalid), 32'(e.owner));
        chk("rdata", e.owner ? cpu_rdata : host_rdata, e.data);
        chk("rdata_non_owner", e.owner ? host_rdata : cpu_rdata, 32'h0);
        chk("rvalid_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic host_op(input logic rw, input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] exp);
    int n = 0;
    host_req = 1'b1; host_rw = rw; host_addr = a; host_wdata = d;
    @(negedge clk);
    while (!host_gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("host_gnt", 32'(host_gnt), 32'd1);
    if (host_gnt && !rw) exp_q.push_back('{1'b0, exp, cyc + 2});
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic cpu_op(input logic rw, input logic [11:0] a, input logic [31:0] d,
                        input logic [31:0] exp, input logic drop_en);
    int n = 0;
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (!cpu_gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cpu_gnt", 32'(cpu_gnt), 32'd1);
    if (cpu_gnt && !rw) exp_q.push_back('{1'b1, exp, cyc + 2});
    @(posedge clk); #1;
    cpu_req = 1'b0;
    if (drop_en) cpu_en = 1'b0;
  endtask

  initial begin
    int busy_cnt, wr_cnt, bad;
    logic served, found;

    reset = 1'b1; cpu_en = 1'b1; clr_mem = 1'b0;
    host_req = 1'b1; host_rw = 1'b1; host_addr = 12'h010; host_wdata = 32'h0000_1111;
    cpu_req  = 1'b1; cpu_rw  = 1'b1; cpu_addr  = 12'h020; cpu_wdata  = 32'h0000_2222;

    // Reset held with every request high: all outputs quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", 32'({host_gnt, cpu_gnt, mem_en, mem_rw, busy, host_rvalid, cpu_rvalid}), 32'h0);
      chk("reset_mem_addr", 32'(mem_addr), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // Continuous contention: host first, then strict alternation.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("contend_host_gnt", 32'(host_gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("contend_cpu_gnt", 32'(cpu_gnt), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("contend_mem_en", 32'(mem_en), (k == 0) ? 32'd0 : 32'd1);
      if (k > 0) chk("contend_mem_addr", 32'(mem_addr), (k % 2 == 1) ? 32'h010 : 32'h020);
    end
    @(posedge clk); #1;
    host_req = 1'b0; cpu_req = 1'b0;

    // Host write then read of the same address.
    host_op(1'b1, 12'h007, 32'h0000_000a, 32'h0);
    host_op(1'b0, 12'h007, 32'h0, 32'h0000_000a);

    // CPU masked while cpu_en=0; host still served.
    cpu_en = 1'b0; cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h008; cpu_wdata = 32'h0000_00ff;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cpu_masked_gnt", 32'(cpu_gnt), 32'd0);
    end
    @(posedge clk); #1;
    host_op(1'b1, 12'h009, 32'h0000_0055, 32'h0);
    cpu_en = 1'b1;
    @(negedge clk);
    chk("cpu_unmasked_gnt", 32'(cpu_gnt), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // CPU read with cpu_en dropped while in flight still returns.
    cpu_op(1'b0, 12'h008, 32'h0, 32'h0000_00ff, 1'b1);
    repeat (3) @(posedge clk);
    #1 cpu_en = 1'b1;

    // Simultaneous reads from both ports return in grant order.
    fork
      host_op(1'b0, 12'h007, 32'h0, 32'h0000_000a);
      cpu_op(1'b0, 12'h009, 32'h0, 32'h0000_0055, 1'b0);
    join

    // Consecutive write then read of one address sees the new value.
    host_op(1'b1, 12'h00A, 32'h0000_1234, 32'h0);
    host_op(1'b0, 12'h00A, 32'h0, 32'h0000_1234);

    // Clear sweep, with a host read pending from the cycle clr_mem is sampled.
    clr_mem = 1'b1; host_req = 1'b1; host_rw = 1'b0; host_addr = 12'h008;
    @(negedge clk);
    chk("clr_beats_req", 32'(host_gnt | cpu_gnt), 32'd0);
    @(posedge clk); #1;
    clr_mem = 1'b0;
    busy_cnt = 0; wr_cnt = 0; bad = 0; served = 1'b0;
    for (int i = 0; i < 4100; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && (host_gnt || cpu_gnt)) bad++;
      if (mem_en && mem_rw) begin
        if (mem_addr !== wr_cnt[11:0] || mem_wdata !== 32'h0) bad++;
        wr_cnt++;
      end
      if (host_gnt && !served) begin
        exp_q.push_back('{1'b0, 32'h0, cyc + 2});
        served = 1'b1;
      end
      @(posedge clk); #1;
      if (served) host_req = 1'b0;
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd4096);
    chk("clear_write_count", 32'(wr_cnt), 32'd4096);
    chk("clear_sweep_errors", 32'(bad), 32'd0);
    chk("clear_then_host_served", 32'(served), 32'd1);

    // Reset in the middle of a sweep.
    clr_mem = 1'b1;
    @(posedge clk); #1;
    clr_mem = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (busy && mem_en && mem_addr == 12'h0FF) found = 1'b1;
    end
    chk("midclear_reached", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    chk("midclear_reset", 32'({busy, mem_en, host_gnt, cpu_gnt}), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_reset_idle", 32'({busy, mem_en}), 32'h0);
    @(posedge clk); #1;
    host_op(1'b0, 12'h00A, 32'h0, 32'h0);

    repeat (6) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
